// File: rtl/mem_rmw_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_rmw_ctrl_pkg
// Description : Shared widths, memory opcodes, FSM states and decode helpers
//               for the LSU read-modify-write controller.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_rmw_ctrl_pkg;

   localparam int CPU_WIDTH    = 32;
   localparam int MEM_OP_WIDTH = 3;

   localparam logic [MEM_OP_WIDTH-1:0] MEM_LB  = 3'd0;
   localparam logic [MEM_OP_WIDTH-1:0] MEM_LH  = 3'd1;
   localparam logic [MEM_OP_WIDTH-1:0] MEM_LW  = 3'd2;
   localparam logic [MEM_OP_WIDTH-1:0] MEM_LBU = 3'd3;
   localparam logic [MEM_OP_WIDTH-1:0] MEM_LHU = 3'd4;
   localparam logic [MEM_OP_WIDTH-1:0] MEM_SB  = 3'd5;
   localparam logic [MEM_OP_WIDTH-1:0] MEM_SH  = 3'd6;
   localparam logic [MEM_OP_WIDTH-1:0] MEM_SW  = 3'd7;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RD_REQ  = 3'd1,
      ST_RD_WAIT = 3'd2,
      ST_WR_REQ  = 3'd3,
      ST_RESP    = 3'd4
   } state_t;

   function automatic logic is_store_op(input logic [MEM_OP_WIDTH-1:0] op);
      return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
   endfunction

   function automatic logic is_misaligned(input logic [MEM_OP_WIDTH-1:0] op,
                                          input logic [1:0]              off);
      logic mis;
      mis = 1'b0;
      case (op)
         MEM_LH, MEM_LHU, MEM_SH: mis = off[0];
         MEM_LW, MEM_SW:          mis = (off != 2'b00);
         default:                 mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_rmw_ctrl_mux_mem.sv
`default_nettype none
// ============================================================================
// Module      : mem_rmw_ctrl_mux_mem
// Description : Store-merge mux; inserts the SB byte / SH halfword into the
//               word read back from memory.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_rmw_ctrl_mux_mem
   import mem_rmw_ctrl_pkg::*;
(
   input  logic [MEM_OP_WIDTH-1:0] op,
   input  logic [1:0]              byte_off,
   input  logic [15:0]             wdata,
   input  logic [CPU_WIDTH-1:0]    rword,
   output logic [CPU_WIDTH-1:0]    merged
);

   always_comb begin
      merged = rword;
      case (op)
         MEM_SB: begin
            case (byte_off)
               2'd0:    merged[7:0]   = wdata[7:0];
               2'd1:    merged[15:8]  = wdata[7:0];
               2'd2:    merged[23:16] = wdata[7:0];
               default: merged[31:24] = wdata[7:0];
            endcase
         end
         MEM_SH: begin
            if (byte_off[1]) merged[31:16] = wdata;
            else             merged[15:0]  = wdata;
         end
         default: merged = rword;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mem_rmw_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_rmw_ctrl
// Description : Sequences LSU loads/stores onto a single-port word memory,
//               using read-modify-write for byte and halfword stores.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_rmw_ctrl
   import mem_rmw_ctrl_pkg::*;
#(
   parameter int RD_TIMEOUT = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    lsu_req,
   output logic                    lsu_ready,
   input  logic [MEM_OP_WIDTH-1:0] lsu_op,
   input  logic                    lsu_we,
   input  logic [CPU_WIDTH-1:0]    lsu_addr,
   input  logic [CPU_WIDTH-1:0]    lsu_wdata,
   output logic                    lsu_done,
   output logic [CPU_WIDTH-1:0]    lsu_rdata,
   output logic                    lsu_err,
   output logic                    mem_req,
   output logic                    mem_we,
   output logic [CPU_WIDTH-1:0]    mem_addr,
   output logic [CPU_WIDTH-1:0]    mem_wdata,
   input  logic                    mem_gnt,
   input  logic                    mem_rvalid,
   input  logic [CPU_WIDTH-1:0]    mem_rdata
);

   localparam int                CNT_W    = $clog2(RD_TIMEOUT + 1);
   localparam logic [CNT_W-1:0]  TO_LIMIT = CNT_W'(RD_TIMEOUT);

   state_t                  state;
   state_t                  state_nxt;
   logic [MEM_OP_WIDTH-1:0] op_q;
   logic [CPU_WIDTH-1:0]    addr_q;
   logic [CPU_WIDTH-1:0]    wdata_q;
   logic [CPU_WIDTH-1:0]    rbuf;
   logic [CPU_WIDTH-1:0]    merged;
   logic [CNT_W-1:0]        cnt;
   logic [CNT_W-1:0]        cnt_inc;
   logic                    drop;
   logic                    err_q;
   logic                    accept;
   logic                    req_bad;
   logic                    rd_timeout;

   assign accept     = lsu_ready && lsu_req;
   assign req_bad    = is_misaligned(lsu_op, lsu_addr[1:0]) || (is_store_op(lsu_op) != lsu_we);
   assign cnt_inc    = cnt + CNT_W'(1);
   assign rd_timeout = (state == ST_RD_WAIT) && !mem_rvalid && (cnt_inc == TO_LIMIT);
   assign mem_addr   = {addr_q[CPU_WIDTH-1:2], 2'b00};
   assign lsu_rdata  = rbuf;
   assign lsu_err    = (state == ST_RESP) && err_q;

   mem_rmw_ctrl_mux_mem u_mux_mem (
      .op       (op_q),
      .byte_off (addr_q[1:0]),
      .wdata    (wdata_q[15:0]),
      .rword    (rbuf),
      .merged   (merged)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      lsu_ready = 1'b0;
      lsu_done  = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_wdata = '0;
      case (state)
         ST_IDLE: begin
            // A read still owed to a timed-out access must drain before new work.
            lsu_ready = !drop;
            if (lsu_ready && lsu_req) begin
               if (req_bad)                state_nxt = ST_RESP;
               else if (lsu_op == MEM_SW)  state_nxt = ST_WR_REQ;
               else                        state_nxt = ST_RD_REQ;
            end
         end
         ST_RD_REQ: begin
            mem_req = 1'b1;
            if (mem_gnt) state_nxt = ST_RD_WAIT;
         end
         ST_RD_WAIT: begin
            if (mem_rvalid) state_nxt = is_store_op(op_q) ? ST_WR_REQ : ST_RESP;
            else if (rd_timeout) state_nxt = ST_RESP;
         end
         ST_WR_REQ: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_wdata = (op_q == MEM_SW) ? wdata_q : merged;
            if (mem_gnt) state_nxt = ST_RESP;
         end
         ST_RESP: begin
            lsu_done  = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q    <= MEM_LB;
         addr_q  <= '0;
         wdata_q <= '0;
         rbuf    <= '0;
         cnt     <= '0;
         drop    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         if (accept) begin
            op_q    <= lsu_op;
            addr_q  <= lsu_addr;
            wdata_q <= lsu_wdata;
            err_q   <= req_bad;
         end
         if ((state == ST_RD_REQ) && mem_gnt) cnt <= '0;
         if (state == ST_RD_WAIT) begin
            if (mem_rvalid) begin
               rbuf <= mem_rdata;
            end else begin
               cnt <= cnt_inc;
               if (rd_timeout) begin
                  err_q <= 1'b1;
                  drop  <= 1'b1;
               end
            end
         end else if (drop && mem_rvalid) begin
            drop <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_rmw_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_rmw_ctrl
// Description : Directed self-checking bench for mem_rmw_ctrl with a simple
//               single-word memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_rmw_ctrl;
   import mem_rmw_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        lsu_req = 1'b0;
   logic        lsu_ready;
   logic [2:0]  lsu_op = MEM_LW;
   logic        lsu_we = 1'b0;
   logic [31:0] lsu_addr = '0;
   logic [31:0] lsu_wdata = '0;
   logic        lsu_done;
   logic [31:0] lsu_rdata;
   logic        lsu_err;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_gnt = 1'b0;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = '0;

   int vectors = 0;
   int miscompares = 0;

   // responder state
   int          gnt_delay = 0;
   int          wait_cnt = 0;
   bit          rvalid_en = 1'b1;
   bit          rv_pend = 1'b0;
   bit          late_rv = 1'b0;
   logic [31:0] late_data = '0;
   logic [31:0] mem_word = '0;
   int          n_rd = 0, n_wr = 0, n_req_cyc = 0, stab_err = 0;
   logic [31:0] rd_addr = '0, wr_addr = '0, wr_data = '0;
   logic [31:0] h_addr = '0, h_wdata = '0;
   logic        h_we = 1'b0;

   mem_rmw_ctrl #(.RD_TIMEOUT(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .lsu_req    (lsu_req),
      .lsu_ready  (lsu_ready),
      .lsu_op     (lsu_op),
      .lsu_we     (lsu_we),
      .lsu_addr   (lsu_addr),
      .lsu_wdata  (lsu_wdata),
      .lsu_done   (lsu_done),
      .lsu_rdata  (lsu_rdata),
      .lsu_err    (lsu_err),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_gnt    (mem_gnt),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata)
   );

   always #5 clk = ~clk;

   // Memory model: drives gnt/rvalid on the falling edge so the DUT sees them at the next rise.
   always @(negedge clk) begin
      mem_rvalid = 1'b0;
      if (rv_pend) begin
         rv_pend = 1'b0;
         if (rvalid_en) begin
            mem_rvalid = 1'b1;
            mem_rdata  = mem_word;
         end
      end
      if (late_rv) begin
         late_rv    = 1'b0;
         mem_rvalid = 1'b1;
         mem_rdata  = late_data;
      end
      mem_gnt = 1'b0;
      if (mem_req) begin
         n_req_cyc++;
         if (wait_cnt == 0) begin
            h_addr = mem_addr; h_we = mem_we; h_wdata = mem_wdata;
         end else if (mem_addr !== h_addr || mem_we !== h_we || mem_wdata !== h_wdata) begin
            stab_err++;
         end
         if (wait_cnt == gnt_delay) begin
            mem_gnt  = 1'b1;
            wait_cnt = 0;
            if (mem_we) begin
               n_wr++; wr_addr = mem_addr; wr_data = mem_wdata;
            end else begin
               n_rd++; rd_addr = mem_addr; rv_pend = 1'b1;
            end
         end else begin
            wait_cnt++;
         end
      end else begin
         wait_cnt = 0;
      end
   end

   // Issues one LSU access and reports the completion cycle (accept edge = cycle 0).
   task automatic do_access(input logic [2:0] op, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, output int lat, output logic err,
                            output logic [31:0] rdata);
      int k;
      lat = -1; err = 1'bx; rdata = 'x;
      k = 0;
      @(negedge clk);
      while (!lsu_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      lsu_op = op; lsu_we = we; lsu_addr = addr; lsu_wdata = wdata; lsu_req = 1'b1;
      @(posedge clk);
      #1 lsu_req = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (lsu_done) begin
            lat = c; err = lsu_err; rdata = lsu_rdata;
            break;
         end
      end
      if (lat < 0) begin
         vectors++; miscompares++;
         $display("FAIL access_timeout op=%0d addr=%h: no lsu_done within 40 cycles", op, addr);
      end
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      vectors++;
      if (mem_req !== 1'b0 || lsu_done !== 1'b0 || lsu_err !== 1'b0 || lsu_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_ctrl got req=%b done=%b err=%b ready=%b expected 0 0 0 1",
                  mem_req, lsu_done, lsu_err, lsu_ready);
      end
      vectors++;
      if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || lsu_rdata !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_data got addr=%h wdata=%h rdata=%h expected all 0",
                  mem_addr, mem_wdata, lsu_rdata);
      end
      rst_n = 1'b1;
      @(negedge clk);
      vectors++;
      if (lsu_ready !== 1'b1 || mem_req !== 1'b0) begin
         miscompares++;
         $display("FAIL post_reset got ready=%b req=%b expected 1 0", lsu_ready, mem_req);
      end
   endtask

   task automatic test_sw;
      int lat; logic err; logic [31:0] rd; int r0, w0;
      r0 = n_rd; w0 = n_wr;
      do_access(MEM_SW, 1'b1, 32'h104, 32'hDEADBEEF, lat, err, rd);
      vectors++;
      if (lat != 2 || err !== 1'b0) begin
         miscompares++;
         $display("FAIL sw_latency got lat=%0d err=%b expected 2 0", lat, err);
      end
      vectors++;
      if (n_wr - w0 != 1 || n_rd != r0 || wr_addr !== 32'h104 || wr_data !== 32'hDEADBEEF) begin
         miscompares++;
         $display("FAIL sw_write got writes=%0d reads=%0d addr=%h data=%h expected 1 0 00000104 deadbeef",
                  n_wr - w0, n_rd - r0, wr_addr, wr_data);
      end
   endtask

   task automatic test_sb;
      int lat; logic err; logic [31:0] rd;
      mem_word = 32'h11223344;
      do_access(MEM_SB, 1'b1, 32'h203, 32'hFFFFFF55, lat, err, rd);
      vectors++;
      if (lat != 4 || err !== 1'b0) begin
         miscompares++;
         $display("FAIL sb_latency got lat=%0d err=%b expected 4 0", lat, err);
      end
      vectors++;
      if (rd_addr !== 32'h200 || wr_addr !== 32'h200 || wr_data !== 32'h55223344) begin
         miscompares++;
         $display("FAIL sb_merge got rd=%h wr=%h data=%h expected 00000200 00000200 55223344",
                  rd_addr, wr_addr, wr_data);
      end
      mem_word = 32'hA0B0C0D0;
      do_access(MEM_SB, 1'b1, 32'h210, 32'h000000EE, lat, err, rd);
      vectors++;
      if (wr_data !== 32'hA0B0C0EE || wr_addr !== 32'h210) begin
         miscompares++;
         $display("FAIL sb_lane0 got addr=%h data=%h expected 00000210 a0b0c0ee", wr_addr, wr_data);
      end
   endtask

   task automatic test_sh_delayed;
      int lat; logic err; logic [31:0] rd; int s0;
      mem_word = 32'h11223344;
      gnt_delay = 3;
      s0 = stab_err;
      do_access(MEM_SH, 1'b1, 32'h302, 32'h5678ABCD, lat, err, rd);
      gnt_delay = 0;
      vectors++;
      if (wr_data !== 32'hABCD3344 || wr_addr !== 32'h300 || err !== 1'b0) begin
         miscompares++;
         $display("FAIL sh_merge got addr=%h data=%h err=%b expected 00000300 abcd3344 0",
                  wr_addr, wr_data, err);
      end
      vectors++;
      if (lat != 10 || stab_err != s0) begin
         miscompares++;
         $display("FAIL sh_delayed got lat=%0d unstable=%0d expected 10 0", lat, stab_err - s0);
      end
   endtask

   task automatic test_misaligned;
      int lat; logic err; logic [31:0] rd; int q0;
      q0 = n_req_cyc;
      do_access(MEM_LW, 1'b0, 32'h401, 32'h0, lat, err, rd);
      vectors++;
      if (lat != 1 || err !== 1'b1 || n_req_cyc != q0) begin
         miscompares++;
         $display("FAIL lw_misaligned got lat=%0d err=%b req_cycles=%0d expected 1 1 0",
                  lat, err, n_req_cyc - q0);
      end
      do_access(MEM_SH, 1'b1, 32'h301, 32'h1234, lat, err, rd);
      vectors++;
      if (lat != 1 || err !== 1'b1 || n_req_cyc != q0) begin
         miscompares++;
         $display("FAIL sh_misaligned got lat=%0d err=%b req_cycles=%0d expected 1 1 0",
                  lat, err, n_req_cyc - q0);
      end
      do_access(MEM_SB, 1'b0, 32'h300, 32'h12, lat, err, rd);
      vectors++;
      if (lat != 1 || err !== 1'b1 || n_req_cyc != q0) begin
         miscompares++;
         $display("FAIL illegal_op got lat=%0d err=%b req_cycles=%0d expected 1 1 0",
                  lat, err, n_req_cyc - q0);
      end
      mem_word = 32'h89ABCDEF;
      do_access(MEM_LH, 1'b0, 32'h402, 32'h0, lat, err, rd);
      vectors++;
      if (lat != 3 || err !== 1'b0 || rd !== 32'h89ABCDEF || rd_addr !== 32'h400) begin
         miscompares++;
         $display("FAIL lh_read got lat=%0d err=%b data=%h addr=%h expected 3 0 89abcdef 00000400",
                  lat, err, rd, rd_addr);
      end
   endtask

   task automatic test_loads;
      int lat; logic err; logic [31:0] rd; int w0;
      w0 = n_wr;
      mem_word = 32'h01020304;
      do_access(MEM_LBU, 1'b0, 32'h603, 32'h0, lat, err, rd);
      vectors++;
      if (lat != 3 || rd !== 32'h01020304 || rd_addr !== 32'h600 || n_wr != w0) begin
         miscompares++;
         $display("FAIL lbu_raw got lat=%0d data=%h addr=%h writes=%0d expected 3 01020304 00000600 0",
                  lat, rd, rd_addr, n_wr - w0);
      end
   endtask

   task automatic test_timeout_drop;
      int lat; logic err; logic [31:0] rd;
      rvalid_en = 1'b0;
      do_access(MEM_LW, 1'b0, 32'h500, 32'h0, lat, err, rd);
      rvalid_en = 1'b1;
      vectors++;
      if (lat != 18 || err !== 1'b1) begin
         miscompares++;
         $display("FAIL rd_timeout got lat=%0d err=%b expected 18 1", lat, err);
      end
      @(negedge clk);
      vectors++;
      if (lsu_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL drop_block got ready=%b expected 0", lsu_ready);
      end
      @(posedge clk);
      #1 begin late_data = 32'hBAD0BAD0; late_rv = 1'b1; end
      @(negedge clk);
      @(negedge clk);
      vectors++;
      if (lsu_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL drop_clear got ready=%b expected 1", lsu_ready);
      end
      mem_word = 32'hCAFEF00D;
      do_access(MEM_LW, 1'b0, 32'h504, 32'h0, lat, err, rd);
      vectors++;
      if (lat != 3 || err !== 1'b0 || rd !== 32'hCAFEF00D) begin
         miscompares++;
         $display("FAIL after_drop got lat=%0d err=%b data=%h expected 3 0 cafef00d", lat, err, rd);
      end
   endtask

   task automatic test_back_to_back;
      int lat; logic err; logic [31:0] rd; int w0;
      do_access(MEM_SW, 1'b1, 32'h700, 32'h11111111, lat, err, rd);
      @(negedge clk);
      vectors++;
      if (lsu_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_ready got ready=%b expected 1", lsu_ready);
      end
      mem_word = 32'h11111111;
      do_access(MEM_SB, 1'b1, 32'h701, 32'h22, lat, err, rd);
      vectors++;
      if (lat != 4 || wr_data !== 32'h11112211) begin
         miscompares++;
         $display("FAIL b2b_sb got lat=%0d data=%h expected 4 11112211", lat, wr_data);
      end
      // A request raised while busy must be dropped, not queued.
      w0 = n_wr;
      gnt_delay = 2;
      fork
         do_access(MEM_SW, 1'b1, 32'h710, 32'h33333333, lat, err, rd);
         begin
            repeat (2) @(negedge clk);
            lsu_op = MEM_SW; lsu_we = 1'b1; lsu_addr = 32'h720; lsu_req = 1'b1;
            @(negedge clk);
            lsu_req = 1'b0;
         end
      join
      gnt_delay = 0;
      repeat (6) @(negedge clk);
      vectors++;
      if (n_wr - w0 != 1 || wr_addr !== 32'h710) begin
         miscompares++;
         $display("FAIL busy_ignore got writes=%0d last=%h expected 1 00000710", n_wr - w0, wr_addr);
      end
   endtask

   task automatic test_reset_wr;
      int w0, q0, k;
      mem_word = 32'h44444444;
      gnt_delay = 5;
      w0 = n_wr;
      @(negedge clk);
      lsu_op = MEM_SB; lsu_we = 1'b1; lsu_addr = 32'h800; lsu_wdata = 32'h99; lsu_req = 1'b1;
      @(posedge clk);
      #1 lsu_req = 1'b0;
      k = 0;
      @(negedge clk);
      while (!(mem_req && mem_we) && k < 30) begin
         @(negedge clk);
         k++;
      end
      #1 rst_n = 1'b0;
      #1;
      vectors++;
      if (k >= 30 || mem_req !== 1'b0 || lsu_ready !== 1'b1 || lsu_rdata !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_in_wr got req=%b ready=%b rdata=%h waited=%0d expected 0 1 0 <30",
                  mem_req, lsu_ready, lsu_rdata, k);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      gnt_delay = 0;
      q0 = n_req_cyc;
      repeat (8) @(negedge clk);
      vectors++;
      if (n_wr != w0 || n_req_cyc != q0 || lsu_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL no_write_after_reset got writes=%0d req_cycles=%0d ready=%b expected 0 0 1",
                  n_wr - w0, n_req_cyc - q0, lsu_ready);
      end
   endtask

   initial begin
      test_reset();
      test_sw();
      test_sb();
      test_sh_delayed();
      test_misaligned();
      test_loads();
      test_timeout_drop();
      test_back_to_back();
      test_reset_wr();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
